// File: rtl/bus_pkg.sv
// Shared types and constants for the 4-bit register bus transfer controller.
package bus_pkg;

   localparam int unsigned BUS_WIDTH = 4;
   localparam int unsigned BUS_NREGS = 4;
   localparam int unsigned BUS_AW    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LATCH = 2'd2
   } xfer_state_e;

   // Register index to one-hot strobe vector; out-of-range indices give all zeros.
   function automatic logic [BUS_NREGS-1:0] idx_onehot(input logic [BUS_AW-1:0] idx);
      logic [BUS_NREGS-1:0] oh;
      oh = '0;
      for (int unsigned i = 0; i < BUS_NREGS; i++) begin
         if (idx == BUS_AW'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Handshake, strobe, bus and observation signals of the register-transfer controller.
interface bus_xfer_ctrl_if
   import bus_pkg::*;
#(
   parameter int unsigned WIDTH = BUS_WIDTH,
   parameter int unsigned NREGS = BUS_NREGS,
   parameter int unsigned AW    = BUS_AW
);

   logic             req_valid;
   logic             req_ready;
   logic [AW-1:0]    req_src;
   logic [AW-1:0]    req_dst;
   logic             ext_load;
   logic [AW-1:0]    ext_dst;
   logic [WIDTH-1:0] ext_data;
   logic [NREGS-1:0] reg_oe;
   logic [NREGS-1:0] reg_ie;
   logic [WIDTH-1:0] bus;
   logic             bus_valid;
   logic             xfer_done;
   logic             xfer_err;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output req_valid, req_src, req_dst, ext_load, ext_dst, ext_data, rd_addr,
      input  req_ready, reg_oe, reg_ie, bus, bus_valid, xfer_done, xfer_err, rd_data
   );

   modport slave (
      input  req_valid, req_src, req_dst, ext_load, ext_dst, ext_data, rd_addr,
      output req_ready, reg_oe, reg_ie, bus, bus_valid, xfer_done, xfer_err, rd_data
   );

endinterface

// File: rtl/bus_regfile.sv
// Bus register array: transfer write (priority) plus external write, bus source and observation read muxes.
module bus_regfile
   import bus_pkg::*;
#(
   parameter int unsigned WIDTH = BUS_WIDTH,
   parameter int unsigned NREGS = BUS_NREGS,
   parameter int unsigned AW    = BUS_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             xfer_we,
   input  logic [AW-1:0]    xfer_addr,
   input  logic [WIDTH-1:0] xfer_data,
   input  logic             ext_we,
   input  logic [AW-1:0]    ext_addr,
   input  logic [WIDTH-1:0] ext_data,
   input  logic [AW-1:0]    src_addr,
   output logic [WIDTH-1:0] src_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] regs [NREGS];

   // Out-of-range write indices match no entry and are silently dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (xfer_we && (xfer_addr == AW'(i))) begin
               regs[i] <= xfer_data;
            end else if (ext_we && (ext_addr == AW'(i))) begin
               regs[i] <= ext_data;
            end
         end
      end
   end

   always_comb begin
      src_data = '0;
      rd_data  = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (src_addr == AW'(i)) src_data = regs[i];
         if (rd_addr == AW'(i))  rd_data  = regs[i];
      end
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-transfer initiator: accepts (src, dst) requests and runs a DRIVE/LATCH strobe sequence on the shared bus.
module bus_xfer_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned WIDTH = BUS_WIDTH,
   parameter int unsigned NREGS = BUS_NREGS,
   parameter int unsigned AW    = BUS_AW
) (
   input  logic            clk,
   input  logic            rst,
   bus_xfer_ctrl_if.slave  bif
);

   xfer_state_e      state;
   logic [AW-1:0]    src_q;
   logic [AW-1:0]    dst_q;
   logic [NREGS-1:0] reg_oe_q;
   logic [NREGS-1:0] reg_ie_q;
   logic             bus_valid_q;
   logic             xfer_done_q;
   logic             xfer_err_q;
   logic [WIDTH-1:0] src_data;
   logic [WIDTH-1:0] bus_c;
   logic             req_ok_c;
   logic             accept_c;

   assign accept_c = bif.req_valid && (state == IDLE);
   assign req_ok_c = (32'(bif.req_src) < NREGS) && (32'(bif.req_dst) < NREGS) &&
                     (bif.req_src != bif.req_dst);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         reg_oe_q    <= '0;
         reg_ie_q    <= '0;
         bus_valid_q <= 1'b0;
         xfer_done_q <= 1'b0;
         xfer_err_q  <= 1'b0;
      end else begin
         xfer_done_q <= 1'b0;
         xfer_err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c && req_ok_c) begin
                  state       <= DRIVE;
                  src_q       <= bif.req_src;
                  dst_q       <= bif.req_dst;
                  reg_oe_q    <= NREGS'(idx_onehot(BUS_AW'(bif.req_src)));
                  bus_valid_q <= 1'b1;
               end else if (accept_c) begin
                  xfer_err_q  <= 1'b1;
               end
            end
            DRIVE: begin
               state    <= LATCH;
               reg_ie_q <= NREGS'(idx_onehot(BUS_AW'(dst_q)));
            end
            LATCH: begin
               state       <= IDLE;
               reg_oe_q    <= '0;
               reg_ie_q    <= '0;
               bus_valid_q <= 1'b0;
               xfer_done_q <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               reg_oe_q    <= '0;
               reg_ie_q    <= '0;
               bus_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // The bus floats to zero whenever no source is enabled.
   assign bus_c = bus_valid_q ? src_data : '0;

   bus_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .xfer_we   (state == LATCH),
      .xfer_addr (dst_q),
      .xfer_data (bus_c),
      .ext_we    (bif.ext_load),
      .ext_addr  (bif.ext_dst),
      .ext_data  (bif.ext_data),
      .src_addr  (src_q),
      .src_data  (src_data),
      .rd_addr   (bif.rd_addr),
      .rd_data   (bif.rd_data)
   );

   assign bif.req_ready = (state == IDLE);
   assign bif.reg_oe    = reg_oe_q;
   assign bif.reg_ie    = reg_ie_q;
   assign bif.bus       = bus_c;
   assign bif.bus_valid = bus_valid_q;
   assign bif.xfer_done = xfer_done_q;
   assign bif.xfer_err  = xfer_err_q;

endmodule
